rx78_bitmap_fetch: RTL and testbench
====================================

# rx78_bitmap_fetch

Bitmap fetch and shift stage that consumes the 256x224-style raster counters from the video timing generator. It produces the palette index for each pixel of the RX-78's 192x184 three-plane bitmap, centred in that raster. It reads VRAM through a single-port, one-cycle-latency read interface and drives the palette/colour stage.

## Interface
Parameters:
- `X_START`, 32: first active hcount; window is 192 wide (32..223).
- `Y_START`, 20: first active vcount; window is 184 tall (20..203).
- `PLANE_STRIDE`, 'h1200: byte distance between bitplane bases in VRAM.

Ports:
- `clk` in 1: pixel clock, same clock as the timing generator.
- `reset` in 1: synchronous, active-high.
- `hcount` in 9: raster column from the timing generator, 0..341.
- `vcount` in 9: raster line from the timing generator, 0..276.
- `hb` in 1: horizontal blank, passed through with pipeline alignment.
- `vb` in 1: vertical blank, passed through with pipeline alignment.
- `vram_addr` out 15: VRAM byte address.
- `vram_rd` out 1: read strobe, one cycle per request.
- `vram_data` in 8: read data, valid exactly one cycle after the `vram_rd` cycle.
- `border` in 3: border palette index (used only with the config macro).
- `pix` out 3: palette index, {plane2, plane1, plane0}.
- `pix_active` out 1: high while `pix` is a bitmap pixel.
- `hb_o` out 1: `hb` delayed 1 cycle.
- `vb_o` out 1: `vb` delayed 1 cycle.

## Operation
- Row active when `Y_START <= vcount < Y_START+184`; row = vcount−Y_START (0..183).
- Column group k (0..23) covers hcount `X_START+8k` .. `X_START+8k+7`.
- Fetch for group k begins at hcount = `X_START−8+8k` (prefetch one group ahead).
- VRAM address for plane p = p*`PLANE_STRIDE` + row*24 + k. Use 15-bit arithmetic; the row*24 term is computed as (row<<4)+(row<<3).
- Fetch FSM states: IDLE, REQ0, REQ1, REQ2, CAP.
  - IDLE→REQ0 on a fetch-start hcount in an active row with `line_ok` set. REQ0 issues plane 0.
  - REQ0→REQ1: issues plane 1 and captures plane 0 data.
  - REQ1→REQ2: issues plane 2 and captures plane 1 data.
  - REQ2→CAP: captures plane 2 data.
  - CAP→IDLE.
  - Captured bytes go to holding registers H0..H2. `vram_rd` is high only in REQ0..REQ2.
- At hcount = `X_START+8k`, H0..H2 load three 8-bit shifters. Each following cycle the shifters shift right. Bit 0 is the leftmost pixel.
- Outside the window, or in inactive rows: `pix`=0 and `pix_active`=0. Holding registers are not loaded.
- `line_ok` sets at hcount==0 and clears on reset. A reset mid-line suppresses fetches until the next line start, so partial groups are never shown.
- No fetch starts after group 23. hcount wrap (341→0) and vcount wrap (276→0) need no special handling beyond the window compares.

## Timing
- Latency: inputs sampled with hcount=X produce `pix`/`pix_active`/`hb_o`/`vb_o` on the next clock edge.
- `pix` for hcount X = column X−`X_START`.
- Fetch occupies 4 of the 8 cycles available per group. It finishes at least 4 cycles before the group's shifter load.
- Reset values: `vram_addr`=0, `vram_rd`=0, `pix`=0, `pix_active`=0, `hb_o`=1, `vb_o`=1. FSM=IDLE, H0..H2=0, shifters=0, `line_ok`=0.
- Reset asserted in any FSM state returns to IDLE on that edge. No read is issued in that cycle.

## Configuration
- Macro `RX78_BORDER_COLOR_EN`.
- Defined: outside the window while `hb`=0 and `vb`=0, `pix`=`border` (registered, same 1-cycle latency) and `pix_active`=0.
- Undefined: `pix`=0 outside the window, and the `border` port is present but ignored.

## Structure
- Shared package `rx78_video_pkg`:
  - Window constants: 192, 184, 24 bytes/line, 3 planes.
  - Fetch FSM state enum.
  - Default `PLANE_STRIDE`.
- One sub-module, `rx78_plane_shifter`: an 8-bit load/shift register, instantiated three times.

## Test plan
- Plane 0 byte at row 0 col 0 = 'h01, others 0. Expect `pix`=1 for the cycle after hcount=32 at vcount=20, and `pix`=0 on the following 7 pixels.
- Planes 0/1/2 at address row 5, k=3 = 'hFF/'h00/'hFF. Expect `pix`=5 for the 8 cycles after hcount 56..63 at vcount=25. Expect `vram_addr` = 123, 'h1200+123 and 'h2400+123 on consecutive `vram_rd` cycles starting at hcount=48.
- Full frame with the timing generator. Count exactly 24×3 `vram_rd` pulses per active line and 0 on lines 0..19 and 204..276. Count 192×184 `pix_active` cycles per frame.
- Assert `reset` at hcount=100, vcount=50. Expect all outputs at reset values next cycle and no `vram_rd` until vcount=51 at hcount=24.
- With `RX78_BORDER_COLOR_EN` and `border`=6: expect `pix`=6 at hcount 0..31 and 224..255, and `pix`=0 at hcount 256 (`hb` high). Without the macro, expect `pix`=0 at those hcounts.
- Row 183, group 23: expect `vram_addr` = 183*24+23 = 4415 for plane 0. Expect no fetch at row 184.

Source files
------------

// File: rtl/rx78_video_pkg.sv
// Shared window constants and fetch FSM encoding for the RX-78 bitmap video path.
package rx78_video_pkg;

  localparam int BMP_W                = 192;
  localparam int BMP_H                = 184;
  localparam int BYTES_PER_LINE       = 24;
  localparam int NUM_PLANES           = 3;
  localparam int DEFAULT_PLANE_STRIDE = 'h1200;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    REQ1,
    REQ2,
    CAP
  } fetch_state_t;

endpackage

// File: rtl/rx78_plane_shifter.sv
// One bitplane's 8-bit load/shift register; bit 0 is the leftmost pixel of the group.
module rx78_plane_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_bit
);

  logic [7:0] r_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= 8'd0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  assign o_bit = r_shift[0];

endmodule

// File: rtl/rx78_bitmap_fetch.sv
// Bitmap fetch/shift stage: prefetches three bitplane bytes per 8-pixel group and shifts out palette indices.
// Optional border colour outside the window is enabled with `define RX78_BORDER_COLOR_EN.
module rx78_bitmap_fetch
  import rx78_video_pkg::*;
#(
  parameter int X_START      = 32,
  parameter int Y_START      = 20,
  parameter int PLANE_STRIDE = DEFAULT_PLANE_STRIDE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hcount,
  input  logic [8:0]  vcount,
  input  logic        hb,
  input  logic        vb,
  output logic [14:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  input  logic [2:0]  border,
  output logic [2:0]  pix,
  output logic        pix_active,
  output logic        hb_o,
  output logic        vb_o
);

  localparam logic [14:0] STRIDE15 = 15'(PLANE_STRIDE);

  fetch_state_t r_state, w_state_nxt;
  logic [14:0] r_vram_addr, w_addr_nxt, r_base, w_base, w_row15;
  logic        r_vram_rd, w_rd_nxt;
  logic        r_line_ok, r_active, r_hb, r_vb;
  logic [2:0]  r_border, w_border_nxt;
  logic [7:0]  r_hold [NUM_PLANES];
  logic [NUM_PLANES-1:0] w_bits;
  logic [9:0]  w_hc, w_vc;
  logic [7:0]  w_row;
  logic [4:0]  w_k;
  logic        w_row_act, w_in_win, w_load, w_fetch_start;

  assign w_hc  = {1'b0, hcount};
  assign w_vc  = {1'b0, vcount};
  assign w_row = 8'(w_vc - 10'(Y_START));
  assign w_k   = 5'((w_hc - 10'(X_START - 8)) >> 3);

  // Window decode is gated by line_ok so a line entered mid-way after reset shows nothing.
  assign w_row_act = (w_vc >= 10'(Y_START)) && (w_vc < 10'(Y_START + BMP_H));
  assign w_in_win  = r_line_ok && w_row_act &&
                     (w_hc >= 10'(X_START)) && (w_hc < 10'(X_START + BMP_W));
  assign w_load    = w_in_win && (3'(w_hc - 10'(X_START)) == 3'd0);
  assign w_fetch_start = r_line_ok && w_row_act &&
                         (w_hc >= 10'(X_START - 8)) &&
                         (w_hc < 10'(X_START - 8 + 8 * BYTES_PER_LINE)) &&
                         (3'(w_hc - 10'(X_START - 8)) == 3'd0);

  assign w_row15 = 15'(w_row);
  assign w_base  = (w_row15 << 4) + (w_row15 << 3) + 15'(w_k);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = 1'b0;
    w_addr_nxt  = r_vram_addr;
    unique case (r_state)
      IDLE: begin
        if (w_fetch_start) begin
          w_state_nxt = REQ0;
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = w_base;
        end
      end
      REQ0: begin
        w_state_nxt = REQ1;
        w_rd_nxt    = 1'b1;
        w_addr_nxt  = r_base + STRIDE15;
      end
      REQ1: begin
        w_state_nxt = REQ2;
        w_rd_nxt    = 1'b1;
        w_addr_nxt  = r_base + (STRIDE15 << 1);
      end
      REQ2:    w_state_nxt = CAP;
      CAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef RX78_BORDER_COLOR_EN
  assign w_border_nxt = (!w_in_win && !hb && !vb) ? border : 3'd0;
`else
  logic w_unused_border;
  assign w_unused_border = ^border;
  assign w_border_nxt    = 3'd0;
`endif

  // Read data trails vram_rd by one cycle, so each plane is captured one state after its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_vram_addr <= 15'd0;
      r_vram_rd   <= 1'b0;
      r_base      <= 15'd0;
      r_line_ok   <= 1'b0;
      r_active    <= 1'b0;
      r_border    <= 3'd0;
      r_hb        <= 1'b1;
      r_vb        <= 1'b1;
      for (int p = 0; p < NUM_PLANES; p++) r_hold[p] <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_vram_addr <= w_addr_nxt;
      r_vram_rd   <= w_rd_nxt;
      if (hcount == 9'd0) r_line_ok <= 1'b1;
      if (r_state == IDLE && w_fetch_start) r_base <= w_base;
      case (r_state)
        REQ1:    r_hold[0] <= vram_data;
        REQ2:    r_hold[1] <= vram_data;
        CAP:     r_hold[2] <= vram_data;
        default: ;
      endcase
      r_active <= w_in_win;
      r_border <= w_border_nxt;
      r_hb     <= hb;
      r_vb     <= vb;
    end
  end

  for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
    rx78_plane_shifter u_shifter (
      .clk   (clk),
      .reset (reset),
      .i_load(w_load),
      .i_data(r_hold[p]),
      .o_bit (w_bits[p])
    );
  end

  assign vram_addr  = r_vram_addr;
  assign vram_rd    = r_vram_rd;
  assign pix        = r_active ? w_bits : r_border;
  assign pix_active = r_active;
  assign hb_o       = r_hb;
  assign vb_o       = r_vb;

endmodule

// File: tb/tb_rx78_bitmap_fetch.sv
// Directed bench for rx78_bitmap_fetch: raster driver, one-cycle VRAM model, hand-computed expectations.
module tb_rx78_bitmap_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hcount, vcount;
  logic        hb, vb;
  logic [14:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [2:0]  border;
  logic [2:0]  pix;
  logic        pix_active, hb_o, vb_o;

  logic [7:0] vram [0:32767];
  int nChecks = 0;
  int nPassed = 0;
  int prevHc, prevVc;
  int expBorder;

  always #5 clk = ~clk;

  rx78_bitmap_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .hb        (hb),
    .vb        (vb),
    .vram_addr (vram_addr),
    .vram_rd   (vram_rd),
    .vram_data (vram_data),
    .border    (border),
    .pix       (pix),
    .pix_active(pix_active),
    .hb_o      (hb_o),
    .vb_o      (vb_o)
  );

  // Single-port VRAM: data for a request appears on the cycle after vram_rd.
  always @(posedge clk) vram_data <= vram_rd ? vram[vram_addr] : 8'h00;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed == expected) nPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic setRaster(input int h, input int v);
    hcount = 9'(h);
    vcount = 9'(v);
    hb = (h >= 256);
    vb = (v >= 224);
  endtask

  // One pixel clock; afterwards the outputs belong to raster position (prevHc, prevVc).
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    prevHc = hcount;
    prevVc = vcount;
    if (prevHc == 341) setRaster(0, (prevVc == 276) ? 0 : prevVc + 1);
    else setRaster(prevHc + 1, prevVc);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"}, vram_addr, 0);
    checkOutput({tag, "_rd"}, vram_rd, 0);
    checkOutput({tag, "_pix"}, pix, 0);
    checkOutput({tag, "_active"}, pix_active, 0);
    checkOutput({tag, "_hb_o"}, hb_o, 1);
    checkOutput({tag, "_vb_o"}, vb_o, 1);
  endtask

  initial begin
    int earlyRd, rdLine, activeTotal, badLines, expRd;
    bit reached, frameDone;

`ifdef RX78_BORDER_COLOR_EN
    expBorder = 6;
`else
    expBorder = 0;
`endif
    for (int a = 0; a < 32768; a++) vram[a] = 8'h00;
    vram[0]             = 8'h01;
    vram[123]           = 8'hFF;
    vram['h1200 + 123]  = 8'h00;
    vram['h2400 + 123]  = 8'hFF;
    vram[4415]          = 8'hA5;

    border = 3'd6;
    reset  = 1'b1;
    hcount = 9'd0;
    vcount = 9'd0;
    hb     = 1'b0;
    vb     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetValues("reset");

    // Mid-line reset at hcount=100, vcount=50
    reset = 1'b0;
    setRaster(0, 49);
    for (int i = 0; i < 442; i++) applyStimulus();
    checkOutput("preResetPos", hcount * 1000 + vcount, 100 * 1000 + 50);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkResetValues("midReset");
    earlyRd = 0;
    reached = 0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      applyStimulus();
      if (prevVc == 51 && prevHc == 24) reached = 1;
      else if (vram_rd) earlyRd++;
    end
    checkOutput("resumeReached", reached, 1);
    checkOutput("earlyRd", earlyRd, 0);
    checkOutput("resumeRd", vram_rd, 1);
    checkOutput("resumeAddr", vram_addr, 31 * 24);
    for (int i = 0; i < 20; i++) applyStimulus();

    // Frame: lines 0..206 then 274..276 (blanked lines 207..273 skipped)
    setRaster(0, 0);
    rdLine = 0;
    activeTotal = 0;
    badLines = 0;
    frameDone = 0;
    for (int i = 0; i < 80000 && !frameDone; i++) begin
      applyStimulus();
      if (vram_rd) rdLine++;
      if (pix_active) activeTotal++;

      if (prevVc == 20) begin
        if (prevHc == 32) begin
          checkOutput("r0c0_pix", pix, 1);
          checkOutput("r0c0_active", pix_active, 1);
        end
        if (prevHc >= 33 && prevHc <= 39)
          checkOutput($sformatf("r0c%0d_pix", prevHc - 32), pix, 0);
        if (prevHc == 31) checkOutput("hc31_active", pix_active, 0);
        if (prevHc == 223) checkOutput("hc223_active", pix_active, 1);
        if (prevHc == 224) checkOutput("hc224_active", pix_active, 0);
        if (prevHc == 0 || prevHc == 31 || prevHc == 224 || prevHc == 255)
          checkOutput($sformatf("border_hc%0d", prevHc), pix, expBorder);
        if (prevHc == 256) checkOutput("hblank_pix", pix, 0);
      end

      if (prevVc == 25) begin
        if (prevHc >= 56 && prevHc <= 63)
          checkOutput($sformatf("r5k3_hc%0d", prevHc), pix, 5);
        if (prevHc == 48) begin
          checkOutput("r5k3_rd0", vram_rd, 1);
          checkOutput("r5k3_addr0", vram_addr, 123);
        end
        if (prevHc == 49) checkOutput("r5k3_addr1", vram_addr, 'h1200 + 123);
        if (prevHc == 50) checkOutput("r5k3_addr2", vram_addr, 'h2400 + 123);
        if (prevHc == 51) checkOutput("r5k3_rdEnd", vram_rd, 0);
      end

      if (prevVc == 203 && prevHc == 208) begin
        checkOutput("r183k23_rd", vram_rd, 1);
        checkOutput("r183k23_addr", vram_addr, 4415);
      end
      if (prevVc == 203 && prevHc == 209)
        checkOutput("r183k23_addr1", vram_addr, 4415 + 'h1200);
      if (prevVc == 203 && prevHc >= 216 && prevHc <= 223)
        checkOutput($sformatf("r183k23_hc%0d", prevHc), pix, (prevHc - 216 == 0 || prevHc - 216 == 2 || prevHc - 216 == 5 || prevHc - 216 == 7) ? 1 : 0);

      if (prevHc == 341) begin
        expRd = (prevVc >= 20 && prevVc < 204) ? 72 : 0;
        if (rdLine != expRd) badLines++;
        if (prevVc == 19 || prevVc == 20 || prevVc == 203 || prevVc == 204)
          checkOutput($sformatf("rdCount_v%0d", prevVc), rdLine, expRd);
        rdLine = 0;
        if (prevVc == 206) setRaster(0, 274);
        if (prevVc == 276) frameDone = 1;
      end
    end
    checkOutput("frameDone", frameDone, 1);
    checkOutput("badRdLines", badLines, 0);
    checkOutput("activeTotal", activeTotal, 192 * 184);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
